// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: micro-op and condition encodings,
// NZCV bit positions and FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        UopNop = 4'd0,
        UopAdd = 4'd1,
        UopSub = 4'd2,
        UopAnd = 4'd3,
        UopOrr = 4'd4,
        UopEor = 4'd5,
        UopMov = 4'd6,
        UopCmp = 4'd7,
        UopLdr = 4'd8,
        UopStr = 4'd9,
        UopB   = 4'd10,
        UopMul = 4'd11
    } uop_t;

    typedef enum logic [3:0] {
        CondEq = 4'd0,
        CondNe = 4'd1,
        CondCs = 4'd2,
        CondCc = 4'd3,
        CondMi = 4'd4,
        CondPl = 4'd5,
        CondVs = 4'd6,
        CondVc = 4'd7,
        CondHi = 4'd8,
        CondLs = 4'd9,
        CondGe = 4'd10,
        CondLt = 4'd11,
        CondGt = 4'd12,
        CondLe = 4'd13,
        CondAl = 4'd14,
        CondNv = 4'd15
    } cond_t;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_t;

endpackage

// File: rtl/exec_cond_eval.sv
// Combinational ARM-style condition evaluation against an NZCV flag vector.
module exec_cond_eval
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FlagN];
    assign z = flags[FlagZ];
    assign c = flags[FlagC];
    assign v = flags[FlagV];

    always_comb begin
        pass = 1'b0;
        unique case (cond_t'(cond))
            CondEq: pass = z;
            CondNe: pass = ~z;
            CondCs: pass = c;
            CondCc: pass = ~c;
            CondMi: pass = n;
            CondPl: pass = ~n;
            CondVs: pass = v;
            CondVc: pass = ~v;
            CondHi: pass = c & ~z;
            CondLs: pass = ~c | z;
            CondGe: pass = (n == v);
            CondLt: pass = (n != v);
            CondGt: pass = ~z & (n == v);
            CondLe: pass = z | (n != v);
            CondAl: pass = 1'b1;
            // NV is treated as always, matching later ARM revisions.
            CondNv: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU, blocking load/store, conditional branch with flush window.
// Optional multiplier enabled by defining EXEC_UNIT_MUL_EN.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_uop,
    input  logic              in_set_flags,
    input  logic [3:0]        in_cond,
    input  logic              in_imm_sel,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] rs0_data,
    input  logic [DATA_W-1:0] rs1_data,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              branch_taken,
    output logic [DATA_W-1:0] delta_instruction,
    output logic              global_disable,
    output logic [3:0]        flags
);

    localparam int unsigned Msb       = DATA_W - 1;
    localparam logic [2:0]  FlushInit = 3'(FLUSH_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [3:0]        flags_q, flags_d;
    logic              ld_pend_q, ld_pend_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;

    logic              wb_en_d, mem_req_d, mem_we_d, bt_d;
    logic [REG_AW-1:0] wb_idx_d;
    logic [DATA_W-1:0] wb_data_d, mem_addr_d, mem_wdata_d, delta_d;

    uop_t              uop;
    logic [DATA_W-1:0] lhs, rhs, alu_res;
    logic [DATA_W:0]   add_full, sub_full;
    logic              alu_wb, alu_upd, c_new, v_new, cond_pass;

    assign uop      = uop_t'(in_uop);
    assign lhs      = rs1_data;
    assign rhs      = in_imm_sel ? in_imm : rs0_data;
    assign add_full = {1'b0, lhs} + {1'b0, rhs};
    // Carry out of lhs + ~rhs + 1 is the ARM "no borrow" carry.
    assign sub_full = {1'b0, lhs} + {1'b0, ~rhs} + {{DATA_W{1'b0}}, 1'b1};

`ifdef EXEC_UNIT_MUL_EN
    logic [DATA_W-1:0] mul_lo;
    assign mul_lo = lhs * rhs;
`endif

    exec_cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        alu_res = '0;
        alu_wb  = 1'b0;
        alu_upd = 1'b0;
        c_new   = flags_q[FlagC];
        v_new   = flags_q[FlagV];
        unique case (uop)
            UopAdd: begin
                alu_res = add_full[Msb:0];
                alu_wb  = 1'b1;
                alu_upd = in_set_flags;
                c_new   = add_full[DATA_W];
                v_new   = (lhs[Msb] == rhs[Msb]) && (alu_res[Msb] != lhs[Msb]);
            end
            UopSub, UopCmp: begin
                alu_res = sub_full[Msb:0];
                alu_wb  = (uop == UopSub);
                alu_upd = in_set_flags || (uop == UopCmp);
                c_new   = sub_full[DATA_W];
                v_new   = (lhs[Msb] != rhs[Msb]) && (alu_res[Msb] != lhs[Msb]);
            end
            UopAnd: begin alu_res = lhs & rhs; alu_wb = 1'b1; alu_upd = in_set_flags; end
            UopOrr: begin alu_res = lhs | rhs; alu_wb = 1'b1; alu_upd = in_set_flags; end
            UopEor: begin alu_res = lhs ^ rhs; alu_wb = 1'b1; alu_upd = in_set_flags; end
            UopMov: begin alu_res = rhs;       alu_wb = 1'b1; alu_upd = in_set_flags; end
`ifdef EXEC_UNIT_MUL_EN
            UopMul: begin alu_res = mul_lo;    alu_wb = 1'b1; alu_upd = in_set_flags; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flags_d     = flags_q;
        ld_pend_d   = ld_pend_q;
        ld_rd_d     = ld_rd_q;
        wb_en_d     = 1'b0;
        wb_idx_d    = wb_idx;
        wb_data_d   = wb_data;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        bt_d        = 1'b0;
        delta_d     = '0;
        unique case (state_q)
            StRun: begin
                if (in_valid) begin
                    if (alu_wb) begin
                        wb_en_d   = 1'b1;
                        wb_idx_d  = in_rd;
                        wb_data_d = alu_res;
                    end
                    if (alu_upd) begin
                        flags_d[FlagN] = alu_res[Msb];
                        flags_d[FlagZ] = (alu_res == '0);
                        flags_d[FlagC] = c_new;
                        flags_d[FlagV] = v_new;
                    end
                    if (uop == UopLdr || uop == UopStr) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (uop == UopStr);
                        mem_addr_d  = add_full[Msb:0];
                        mem_wdata_d = rs0_data;
                        ld_pend_d   = (uop == UopLdr);
                        ld_rd_d     = in_rd;
                        state_d     = StMemWait;
                    end
                    if (uop == UopB && cond_pass) begin
                        bt_d        = 1'b1;
                        delta_d     = in_imm;
                        flush_cnt_d = FlushInit;
                        state_d     = StFlush;
                    end
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = StRun;
                    if (ld_pend_q) begin
                        wb_en_d   = 1'b1;
                        wb_idx_d  = ld_rd_q;
                        wb_data_d = mem_rdata;
                    end
                end
            end
            StFlush: begin
                if (in_valid) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StRun;
            flush_cnt_q       <= '0;
            flags_q           <= '0;
            ld_pend_q         <= 1'b0;
            ld_rd_q           <= '0;
            wb_en             <= 1'b0;
            wb_idx            <= '0;
            wb_data           <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            branch_taken      <= 1'b0;
            delta_instruction <= '0;
        end else begin
            state_q           <= state_d;
            flush_cnt_q       <= flush_cnt_d;
            flags_q           <= flags_d;
            ld_pend_q         <= ld_pend_d;
            ld_rd_q           <= ld_rd_d;
            wb_en             <= wb_en_d;
            wb_idx            <= wb_idx_d;
            wb_data           <= wb_data_d;
            mem_req           <= mem_req_d;
            mem_we            <= mem_we_d;
            mem_addr          <= mem_addr_d;
            mem_wdata         <= mem_wdata_d;
            branch_taken      <= bt_d;
            delta_instruction <= delta_d;
        end
    end

    assign in_ready       = (state_q != StMemWait);
    assign global_disable = (state_q == StFlush);
    assign flags          = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid, in_ready, in_set_flags, in_imm_sel;
    logic [3:0]    in_uop, in_cond, flags;
    logic [DW-1:0] in_imm, rs0_data, rs1_data, wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [DW-1:0] delta_instruction;
    logic [AW-1:0] in_rd, wb_idx;
    logic          wb_en, mem_req, mem_we, mem_ack, branch_taken, global_disable;

    always #5 clk = ~clk;

    exec_unit #(.DATA_W(DW), .REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .in_set_flags(in_set_flags), .in_cond(in_cond), .in_imm_sel(in_imm_sel),
        .in_imm(in_imm), .in_rd(in_rd), .rs0_data(rs0_data), .rs1_data(rs1_data),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .branch_taken(branch_taken), .delta_instruction(delta_instruction),
        .global_disable(global_disable), .flags(flags)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: mode 0 = running, 1 = waiting on memory, 2 = discarding after a branch.
    int            m_mode, m_left;
    logic [3:0]    m_flags;
    bit            m_load;
    logic [AW-1:0] m_rd;
    bit            e_wb_en, e_bt, e_mem_req, e_mem_we;
    logic [AW-1:0] e_wb_idx;
    logic [DW-1:0] e_wb_data, e_delta, e_mem_addr, e_mem_wdata;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_flags = '0; m_load = 0; m_rd = '0;
        e_wb_en = 0; e_bt = 0; e_mem_req = 0; e_mem_we = 0;
        e_wb_idx = '0; e_wb_data = '0; e_delta = '0; e_mem_addr = '0; e_mem_wdata = '0;
    endtask

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1;
        endcase
    endfunction

    // Applies the effect of the rising edge just passed, using the inputs held across it.
    task automatic model_edge();
        logic [DW-1:0] lhs, rhs, res;
        longint        s;
        bit            wr, setf, cv, c, v;
        e_wb_en = 0; e_bt = 0; e_delta = '0;
        if (m_mode == 1) begin
            if (mem_ack) begin
                m_mode = 0;
                e_mem_req = 0;
                if (m_load) begin e_wb_en = 1; e_wb_idx = m_rd; e_wb_data = mem_rdata; end
            end
        end else if (m_mode == 2) begin
            if (in_valid) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end else if (in_valid) begin
            lhs = rs1_data;
            rhs = in_imm_sel ? in_imm : rs0_data;
            wr = 0; setf = 0; cv = 0; c = 0; v = 0; res = '0;
            case (in_uop)
                UopAdd: begin
                    res = lhs + rhs; wr = 1; setf = in_set_flags; cv = 1;
                    c = ((longint'(lhs) + longint'(rhs)) >> 32) != 0;
                    s = longint'($signed(lhs)) + longint'($signed(rhs));
                    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                UopSub, UopCmp: begin
                    res = lhs - rhs; cv = 1;
                    wr = (in_uop == UopSub);
                    setf = in_set_flags || (in_uop == UopCmp);
                    c = (lhs >= rhs);
                    s = longint'($signed(lhs)) - longint'($signed(rhs));
                    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                UopAnd: begin res = lhs & rhs; wr = 1; setf = in_set_flags; end
                UopOrr: begin res = lhs | rhs; wr = 1; setf = in_set_flags; end
                UopEor: begin res = lhs ^ rhs; wr = 1; setf = in_set_flags; end
                UopMov: begin res = rhs;       wr = 1; setf = in_set_flags; end
`ifdef EXEC_UNIT_MUL_EN
                UopMul: begin res = lhs * rhs; wr = 1; setf = in_set_flags; end
`endif
                UopLdr, UopStr: begin
                    e_mem_req = 1; e_mem_addr = lhs + rhs; e_mem_we = (in_uop == UopStr);
                    e_mem_wdata = rs0_data; m_load = (in_uop == UopLdr); m_rd = in_rd;
                    m_mode = 1;
                end
                UopB: begin
                    if (cond_true(in_cond, m_flags)) begin
                        e_bt = 1; e_delta = in_imm; m_mode = 2; m_left = FC;
                    end
                end
                default: ;
            endcase
            if (wr) begin e_wb_en = 1; e_wb_idx = in_rd; e_wb_data = res; end
            if (setf) begin
                m_flags[3] = res[DW-1];
                m_flags[2] = (res == '0);
                if (cv) begin m_flags[1] = c; m_flags[0] = v; end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("in_ready", in_ready, m_mode != 1);
        check_eq("global_disable", global_disable, m_mode == 2);
        check_eq("branch_taken", branch_taken, e_bt);
        check_eq("delta", delta_instruction, e_delta);
        check_eq("flags", flags, m_flags);
        check_eq("wb_en", wb_en, e_wb_en);
        if (e_wb_en) begin
            check_eq("wb_idx", wb_idx, e_wb_idx);
            check_eq("wb_data", wb_data, e_wb_data);
        end
        check_eq("mem_req", mem_req, e_mem_req);
        if (e_mem_req) begin
            check_eq("mem_addr", mem_addr, e_mem_addr);
            check_eq("mem_we", mem_we, e_mem_we);
            if (e_mem_we) check_eq("mem_wdata", mem_wdata, e_mem_wdata);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [3:0] u, input bit sf, input logic [3:0] cnd,
                         input bit isel, input logic [DW-1:0] imm, input logic [AW-1:0] rd,
                         input logic [DW-1:0] r0, input logic [DW-1:0] r1, input bit ack,
                         input logic [DW-1:0] rdata);
        in_valid = v; in_uop = u; in_set_flags = sf; in_cond = cnd; in_imm_sel = isel;
        in_imm = imm; in_rd = rd; rs0_data = r0; rs1_data = r1; mem_ack = ack;
        mem_rdata = rdata;
        cycle();
    endtask

    task automatic idle(input bit ack);
        drive(0, UopNop, 0, 4'd0, 0, '0, '0, '0, '0, ack, '0);
    endtask

    initial begin
        in_valid = 0; in_uop = '0; in_set_flags = 0; in_cond = '0; in_imm_sel = 0;
        in_imm = '0; in_rd = '0; rs0_data = '0; rs1_data = '0; mem_ack = 0; mem_rdata = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_wb_en", wb_en, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_branch", branch_taken, 0);
        check_eq("rst_gd", global_disable, 0);
        check_eq("rst_wb_data", wb_data, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Signed overflow on ADD.
        drive(1, UopAdd, 1, 4'd0, 1, 32'd1, 4'd3, '0, 32'h7FFF_FFFF, 0, '0);
        check_eq("add_wb_data", wb_data, 32'h8000_0000);
        check_eq("add_nzcv", flags, 4'b1001);

        // CMP then taken BEQ, two discarded instructions, then a live one.
        drive(1, UopCmp, 0, 4'd0, 0, '0, 4'd1, 32'd5, 32'd5, 0, '0);
        check_eq("cmp_no_wb", wb_en, 0);
        drive(1, UopB, 0, CondEq, 1, 32'hFFFF_FFF8, 4'd0, '0, '0, 0, '0);
        check_eq("beq_taken", branch_taken, 1);
        check_eq("beq_delta", delta_instruction, 32'hFFFF_FFF8);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd2, '0, 32'd1, 0, '0);
        check_eq("flush1_no_wb", wb_en, 0);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd2, '0, 32'd1, 0, '0);
        check_eq("flush2_no_wb", wb_en, 0);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd2, '0, 32'd1, 0, '0);
        check_eq("post_flush_wb", wb_en, 1);

        // Load with a delayed ack.
        drive(1, UopLdr, 0, 4'd0, 1, 32'd4, 4'd7, '0, 32'h100, 0, '0);
        check_eq("ldr_addr", mem_addr, 32'h104);
        for (int i = 0; i < 2; i++) begin
            drive(1, UopAdd, 0, 4'd0, 1, 32'd9, 4'd1, '0, '0, 0, '0);
            check_eq("ldr_wait_ready", in_ready, 0);
            check_eq("ldr_wait_addr", mem_addr, 32'h104);
        end
        drive(0, UopNop, 0, 4'd0, 0, '0, '0, '0, '0, 1, 32'hDEAD_BEEF);
        check_eq("ldr_wb_en", wb_en, 1);
        check_eq("ldr_wb_data", wb_data, 32'hDEAD_BEEF);

        // Store acked in its first request cycle.
        drive(1, UopStr, 0, 4'd0, 1, 32'd8, 4'd0, 32'h1234, 32'h200, 0, '0);
        idle(1);
        check_eq("str_done_ready", in_ready, 1);
        drive(1, UopMov, 0, 4'd0, 1, 32'd77, 4'd5, '0, '0, 0, '0);
        check_eq("str_next_wb", wb_en, 1);

        // Reset while waiting, then a stray ack.
        drive(1, UopLdr, 0, 4'd0, 1, 32'd0, 4'd4, '0, 32'h300, 0, '0);
        idle(0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_wait_mem_req", mem_req, 0);
        check_eq("rst_wait_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);
        check_eq("late_ack_no_wb", wb_en, 0);

        // Flush window with valid gaps.
        drive(1, UopB, 0, CondAl, 1, 32'd16, 4'd0, '0, '0, 0, '0);
        drive(0, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        drive(0, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        drive(0, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        check_eq("gap_still_flushing", global_disable, 1);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        check_eq("gap_discard_last", wb_en, 0);
        drive(1, UopAdd, 0, 4'd0, 1, 32'd1, 4'd6, '0, '0, 0, '0);
        check_eq("gap_resume_wb", wb_en, 1);
        check_eq("gap_resume_gd", global_disable, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom_range(0, 15)), 1'($urandom % 2),
                  4'($urandom), 1'($urandom % 2),
                  ($urandom % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  4'($urandom), $urandom, ($urandom % 4 == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom % 3) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
